// File: rtl/cache_dados_assoc.sv
// cache_dados_assoc: 2-way set-associative write-back/write-allocate L1 data cache with true LRU.
// Optional saturating hit/miss/writeback counters when CACHE_DADOS_STATS_EN is defined.
module cache_dados_assoc #(
  parameter int NUM_SETS        = 4,
  parameter int WORDS_PER_BLOCK = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [31:0]                  cpu_addr,
  input  logic [63:0]                  cpu_wdata,
  output logic [63:0]                  cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_hit,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [64*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic [64*WORDS_PER_BLOCK-1:0] mem_rdata,
  input  logic                         mem_ready
`ifdef CACHE_DADOS_STATS_EN
  ,
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_misses,
  output logic [31:0]                  stat_writebacks
`endif
);
  localparam int BLOCK_BITS = 64 * WORDS_PER_BLOCK;
  localparam int WSW  = $clog2(WORDS_PER_BLOCK);
  localparam int OFF  = 3 + WSW;
  localparam int IDXW = $clog2(NUM_SETS);
  localparam int TAGW = 32 - OFF - IDXW;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state, nxt;
  logic [31:0] req_addr;
  logic req_we;
  logic [63:0] req_wdata;
  logic vway;
  logic [1:0][NUM_SETS-1:0] valid, dirty;
  logic [NUM_SETS-1:0] lru;
  logic [TAGW-1:0] tags [2][NUM_SETS];
  logic [BLOCK_BITS-1:0] blocks [2][NUM_SETS];
  logic [31:0] addr;
  logic we;
  logic [63:0] wdata;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [WSW-1:0] w;
  logic hit0, hit1, hit, hway, victim, wb_need, hit_upd, ref_upd, wr_way;
  logic [BLOCK_BITS-1:0] merged;
  logic unused;
  assign unused = ^{cpu_addr[2:0], req_addr[2:0]};
  // In IDLE the live request is looked up; afterwards the latched one drives the same datapath.
  always_comb begin
    addr    = state == IDLE ? cpu_addr : req_addr;
    we      = state == IDLE ? cpu_we : req_we;
    wdata   = state == IDLE ? cpu_wdata : req_wdata;
    idx     = addr[OFF +: IDXW];
    tag     = addr[31 -: TAGW];
    w       = addr[3 +: WSW];
    hit0    = valid[0][idx] && tags[0][idx] == tag;
    hit1    = valid[1][idx] && tags[1][idx] == tag;
    hit     = hit0 || hit1;
    hway    = hit1;
    victim  = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
    wb_need = valid[victim][idx] && dirty[victim][idx];
    hit_upd = state == IDLE && cpu_req && hit;
    ref_upd = state == REFILL && mem_ready;
    wr_way  = state == IDLE ? hway : vway;
    merged  = state == IDLE ? blocks[hway][idx] : mem_rdata;
    if (we) merged[{w, 6'd0} +: 64] = wdata;
    nxt = state == IDLE ? (cpu_req && !hit ? (wb_need ? WRITEBACK : REFILL) : IDLE)
        : !mem_ready ? state : state == WRITEBACK ? REFILL : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if ((hit_upd && we) || ref_upd) blocks[wr_way][idx] <= merged;
    if (ref_upd) tags[vway][idx] <= tag;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      vway      <= 1'b0;
      valid     <= '0;
      dirty     <= '0;
      lru       <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      if (state == IDLE && cpu_req) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
        if (hit) begin
          cpu_ready <= 1'b1;
          cpu_hit   <= 1'b1;
          cpu_rdata <= merged[{w, 6'd0} +: 64];
          lru[idx]  <= ~hway;
          if (cpu_we) dirty[hway][idx] <= 1'b1;
        end else begin
          vway      <= victim;
          mem_req   <= 1'b1;
          mem_we    <= wb_need;
          mem_addr  <= {wb_need ? tags[victim][idx] : tag, idx, {OFF{1'b0}}};
          mem_wdata <= blocks[victim][idx];
        end
      end else if (state == WRITEBACK && mem_ready) begin
        mem_we   <= 1'b0;
        mem_addr <= {tag, idx, {OFF{1'b0}}};
      end else if (ref_upd) begin
        mem_req           <= 1'b0;
        valid[vway][idx]  <= 1'b1;
        dirty[vway][idx]  <= req_we;
        lru[idx]          <= ~vway;
        cpu_ready         <= 1'b1;
        cpu_rdata         <= merged[{w, 6'd0} +: 64];
      end
    end
`ifdef CACHE_DADOS_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (hit_upd && ~&stat_hits) stat_hits <= stat_hits + 1'b1;
      if (ref_upd && ~&stat_misses) stat_misses <= stat_misses + 1'b1;
      if (state == WRITEBACK && mem_ready && ~&stat_writebacks) stat_writebacks <= stat_writebacks + 1'b1;
    end
`endif
endmodule

// File: tb/tb_cache_dados_assoc.sv
// tb_cache_dados_assoc: directed + random accesses against an LRU/golden-memory reference model.
module tb_cache_dados_assoc;
  logic clk = 1'b0, reset;
  logic cpu_req, cpu_we, cpu_ready, cpu_hit, mem_req, mem_we, mem_ready;
  logic [31:0] cpu_addr, mem_addr;
  logic [63:0] cpu_wdata, cpu_rdata;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef CACHE_DADOS_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif
  int checks = 0, failures = 0;
  bit [127:0] mem [bit [31:0]];
  bit [63:0] gold [bit [31:0]];
  int mtag [4][2];
  bit mdirty [4][2];
  int mcnt [4];
  int wb_cnt = 0, rf_cnt = 0, wait_cnt = 0;
  bit [31:0] wb_addr, rf_addr;
  bit [127:0] wb_data;
  bit hold_mem = 1'b0;

  cache_dados_assoc dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_DADOS_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit [127:0] memblk(bit [31:0] b);
    return mem.exists(b) ? mem[b] : {b ^ 32'hA5A5_0000, ~b, b + 32'h8, b ^ 32'h5A5A_FFFF};
  endfunction

  function automatic bit [63:0] gword(bit [31:0] a);
    bit [127:0] blk;
    if (gold.exists(a)) return gold[a];
    blk = memblk(a & ~32'hF);
    return a[3] ? blk[127:64] : blk[63:0];
  endfunction

  // Block-level memory: answers each transaction after a random 1..3 cycle wait.
  always @(negedge clk) begin
    if (!reset || hold_mem) begin
      mem_ready = 1'b0;
      wait_cnt = 0;
    end else if (mem_ready) mem_ready = 1'b0;
    else if (mem_req) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        if (mem_we) begin
          wb_cnt++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
          mem[mem_addr] = mem_wdata;
        end else begin
          rf_cnt++;
          rf_addr = mem_addr;
          mem_rdata = memblk(mem_addr);
        end
        mem_ready = 1'b1;
        wait_cnt = $urandom_range(0, 2);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) mcnt[s] = 0;
    gold.delete();
  endtask

  // Called at a negedge; returns at the negedge where cpu_ready is seen, so calls chain back-to-back.
  task automatic access(input bit [31:0] a, input bit we, input bit [63:0] d);
    int s = int'((a >> 4) & 3);
    int t = int'(a >> 6);
    int pos = -1;
    int cyc = 0;
    int wb0 = wb_cnt, rf0 = rf_cnt;
    bit exp_wb = 1'b0;
    bit [31:0] wba = '0;
    bit [127:0] exp_wbd = '0;
    bit [63:0] exp_rd = gword(a & ~32'h7);
    for (int i = 0; i < mcnt[s]; i++) if (mtag[s][i] == t) pos = i;
    if (pos >= 0) begin
      if (pos == 1) begin
        mtag[s][1] = mtag[s][0];
        mtag[s][0] = t;
        {mdirty[s][0], mdirty[s][1]} = {mdirty[s][1], mdirty[s][0]};
      end
      mdirty[s][0] |= we;
    end else begin
      if (mcnt[s] == 2 && mdirty[s][1]) begin
        exp_wb = 1'b1;
        wba = (32'(mtag[s][1]) << 6) | (32'(s) << 4);
        exp_wbd = {gword(wba + 32'h8), gword(wba)};
      end
      mtag[s][1] = mtag[s][0];
      mdirty[s][1] = mdirty[s][0];
      mtag[s][0] = t;
      mdirty[s][0] = we;
      if (mcnt[s] < 2) mcnt[s]++;
    end
    if (we) gold[a & ~32'h7] = d;
    cpu_req = 1'b1;
    cpu_addr = a;
    cpu_we = we;
    cpu_wdata = d;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_ready && cyc < 100);
    chk($sformatf("ready@%0h", a), cpu_ready, 1'b1);
    chk($sformatf("hit@%0h", a), cpu_hit, pos >= 0);
    if (pos >= 0) chk($sformatf("hit_latency@%0h", a), cyc, 1);
    if (!we) chk($sformatf("rdata@%0h", a), cpu_rdata, exp_rd);
    chk($sformatf("wb_count@%0h", a), wb_cnt - wb0, exp_wb);
    if (exp_wb) begin
      chk($sformatf("wb_addr@%0h", a), wb_addr, wba);
      chk($sformatf("wb_data@%0h", a), wb_data, exp_wbd);
    end
    chk($sformatf("refill_count@%0h", a), rf_cnt - rf0, pos < 0);
    if (pos < 0) chk($sformatf("refill_addr@%0h", a), rf_addr, a & ~32'hF);
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_cpu_ready", cpu_ready, 1'b0);
    chk("reset_cpu_hit", cpu_hit, 1'b0);
    chk("reset_cpu_rdata", cpu_rdata, 64'h0);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_we", mem_we, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 128'h0);
    reset = 1'b1;
    mem[32'h100] = {64'hBBBB_0000_BBBB_1111, 64'hAAAA_0000_AAAA_1111};
    access(32'h100, 1'b0, '0);
    access(32'h108, 1'b0, '0);
`ifdef CACHE_DADOS_STATS_EN
    chk("stat_hits", stat_hits, 32'd1);
    chk("stat_misses", stat_misses, 32'd1);
    chk("stat_writebacks", stat_writebacks, 32'd0);
`endif
    access(32'h100, 1'b1, 64'hDEAD);
    access(32'h100, 1'b0, '0);
    access(32'h000, 1'b0, '0);
    access(32'h040, 1'b0, '0);
    access(32'h000, 1'b0, '0);
    access(32'h080, 1'b0, '0);
    access(32'h000, 1'b0, '0);
    access(32'h040, 1'b1, 64'h55);
    access(32'h0C0, 1'b0, '0);
    access(32'h140, 1'b0, '0);
    // Abort a clean refill with reset while memory withholds mem_ready.
    hold_mem = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 32'h310;
    cpu_we = 1'b0;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_req_before", mem_req, 1'b1);
    chk("abort_mem_we_before", mem_we, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_cpu_ready", cpu_ready, 1'b0);
    chk("abort_cpu_rdata", cpu_rdata, 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    hold_mem = 1'b0;
    access(32'h310, 1'b0, '0);
    for (int n = 0; n < 200; n++)
      access((32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 1)) << 3),
             1'($urandom_range(0, 1)), {$urandom, $urandom});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
